// File: rtl/ram_readback_checker.sv
// Read-back verifier: walks all RAM words, compares each against ROM[rom_base + index]
// and reports pass, mismatch count and the first failing RAM address.
module ram_readback_checker #(
  parameter int DATA_W = 16,
  parameter int RAM_AW = 2,
  parameter int ROM_AW = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ROM_AW-1:0] rom_base,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rw,
  output logic              ram_cs,
  input  logic [DATA_W-1:0] ram_data,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        mismatch_count,
  output logic [RAM_AW-1:0] first_fail_addr
);

  typedef enum logic [1:0] {IDLE, ISSUE, CMP, DONE} state_t;

  state_t            state;
  logic [ROM_AW-1:0] base_q;
  logic [RAM_AW-1:0] idx;
  logic [RAM_AW-1:0] idx_next;
  logic              word_diff;
  logic              last_word;
  logic [2:0]        count_next;

  assign ram_rw     = 1'b0;
  assign idx_next   = idx + 1'b1;
  assign word_diff  = (ram_data != rom_data);
  assign last_word  = &idx;
  assign count_next = mismatch_count + {2'b00, word_diff};

  // Addresses are registered one step ahead so they stay stable across ISSUE and CMP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      base_q          <= '0;
      idx             <= '0;
      ram_addr        <= '0;
      rom_addr        <= '0;
      ram_cs          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch_count  <= '0;
      first_fail_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            base_q          <= rom_base;
            idx             <= '0;
            mismatch_count  <= '0;
            first_fail_addr <= '0;
            pass            <= 1'b0;
            ram_addr        <= '0;
            rom_addr        <= rom_base;
            ram_cs          <= 1'b1;
            busy            <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CMP;
        end
        CMP: begin
          if (word_diff) begin
            mismatch_count <= count_next;
            if (mismatch_count == 3'd0) begin
              first_fail_addr <= idx;
            end
          end
          if (last_word) begin
            ram_cs <= 1'b0;
            done   <= 1'b1;
            pass   <= (count_next == 3'd0);
            state  <= DONE;
          end else begin
            // ROM address wraps naturally: the carry out of the 4-bit add is dropped.
            idx      <= idx_next;
            ram_addr <= idx_next;
            rom_addr <= base_q + ROM_AW'(idx_next);
            state    <= ISSUE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_readback_checker.sv
// Self-checking bench for ram_readback_checker: directed plus randomized passes,
// memories and expected results modelled here with plain array arithmetic.
module tb_ram_readback_checker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  rom_base;
  logic [1:0]  ram_addr;
  logic        ram_rw;
  logic        ram_cs;
  logic [15:0] ram_data;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  mismatch_count;
  logic [1:0]  first_fail_addr;

  logic [15:0] ram_mem [4];
  logic [15:0] rom_mem [16];

  int errors = 0;
  int checks = 0;

  int exp_count;
  int exp_first;
  int exp_pass;

  always #5 clock = ~clock;

  assign ram_data = ram_mem[ram_addr];
  assign rom_data = rom_mem[rom_addr];

  ram_readback_checker #(.DATA_W(16), .RAM_AW(2), .ROM_AW(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .rom_base(rom_base),
    .ram_addr(ram_addr),
    .ram_rw(ram_rw),
    .ram_cs(ram_cs),
    .ram_data(ram_data),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy(busy),
    .done(done),
    .pass(pass),
    .mismatch_count(mismatch_count),
    .first_fail_addr(first_fail_addr)
  );

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Expected results straight from the rule: count differing words, lowest failing index.
  task automatic model_pass(input int base);
    exp_count = 0;
    exp_first = 0;
    for (int i = 0; i < 4; i++) begin
      if (ram_mem[i] != rom_mem[(base + i) % 16]) begin
        if (exp_count == 0) exp_first = i;
        exp_count++;
      end
    end
    exp_pass = (exp_count == 0) ? 1 : 0;
  endtask

  // Negedge k after the accepting edge shows the cycle after edge E(k-1).
  task automatic apply_stimulus(input string name, input int base, input int glitch_k);
    int done_seen;
    done_seen = 0;
    model_pass(base);
    @(negedge clock);
    rom_base = 4'(base);
    start    = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1 || k == glitch_k + 1) start = 1'b0;
      rom_base = 4'($urandom_range(0, 15));
      if (done === 1'b1) done_seen++;
      check_output($sformatf("%s rw k%0d", name, k), int'(ram_rw), 0);
      check_output($sformatf("%s busy k%0d", name, k), int'(busy), (k <= 9) ? 1 : 0);
      check_output($sformatf("%s done k%0d", name, k), int'(done), (k == 9) ? 1 : 0);
      check_output($sformatf("%s cs k%0d", name, k), int'(ram_cs), (k <= 8) ? 1 : 0);
      if (k <= 8) begin
        check_output($sformatf("%s ram_addr k%0d", name, k), int'(ram_addr), (k - 1) / 2);
        check_output($sformatf("%s rom_addr k%0d", name, k), int'(rom_addr),
                     (base + (k - 1) / 2) % 16);
      end
      if (k >= 9) begin
        check_output($sformatf("%s pass k%0d", name, k), int'(pass), exp_pass);
        check_output($sformatf("%s count k%0d", name, k), int'(mismatch_count), exp_count);
        check_output($sformatf("%s first k%0d", name, k), int'(first_fail_addr), exp_first);
      end
      if (k == glitch_k) start = 1'b1;
    end
    check_output({name, " done pulses"}, done_seen, 1);
  endtask

  initial begin
    for (int i = 0; i < 15; i++) rom_mem[i] = 16'(i);
    rom_mem[15] = 16'h0069;
    for (int i = 0; i < 4; i++) ram_mem[i] = 16'h0000;
    reset_n  = 1'b0;
    start    = 1'b0;
    rom_base = 4'd0;
    repeat (2) @(negedge clock);
    check_output("reset busy", int'(busy), 0);
    check_output("reset done", int'(done), 0);
    check_output("reset cs", int'(ram_cs), 0);
    check_output("reset pass", int'(pass), 0);
    check_output("reset count", int'(mismatch_count), 0);
    check_output("reset first", int'(first_fail_addr), 0);
    check_output("reset ram_addr", int'(ram_addr), 0);
    check_output("reset rom_addr", int'(rom_addr), 0);
    reset_n = 1'b1;

    ram_mem[0] = 16'h000C; ram_mem[1] = 16'h000D; ram_mem[2] = 16'h000E; ram_mem[3] = 16'h0069;
    apply_stimulus("match12", 12, 0);
    check_output("match12 model pass", exp_pass, 1);

    ram_mem[2] = 16'h00FF;
    apply_stimulus("bad2", 12, 0);
    check_output("bad2 model count", exp_count, 1);

    for (int i = 0; i < 4; i++) ram_mem[i] = 16'h0000;
    apply_stimulus("zeros", 1, 0);
    check_output("zeros model count", exp_count, 4);

    ram_mem[0] = 16'h000E; ram_mem[1] = 16'h0069; ram_mem[2] = 16'h0000; ram_mem[3] = 16'h0001;
    apply_stimulus("wrap14", 14, 0);

    apply_stimulus("restart_cmp1", 14, 4);

    // Abort mid-pass: word 0 mismatches so the count is nonzero when reset hits.
    ram_mem[0] = 16'hBEEF;
    @(negedge clock);
    rom_base = 4'd14;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    check_output("pre-abort count", int'(mismatch_count), 1);
    reset_n = 1'b0;
    #1;
    check_output("abort busy", int'(busy), 0);
    check_output("abort cs", int'(ram_cs), 0);
    check_output("abort count", int'(mismatch_count), 0);
    check_output("abort pass", int'(pass), 0);
    check_output("abort done", int'(done), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_output($sformatf("abort hold done %0d", k), int'(done), 0);
    end
    reset_n = 1'b1;
    ram_mem[0] = 16'h000E;
    apply_stimulus("after_abort", 14, 0);

    for (int r = 0; r < 8; r++) begin
      int base;
      base = $urandom_range(0, 15);
      for (int i = 0; i < 4; i++) begin
        ram_mem[i] = ($urandom_range(0, 1) == 1) ? rom_mem[(base + i) % 16] : 16'($urandom);
      end
      apply_stimulus($sformatf("rand%0d", r), base, 0);
    end

    $display("[TB] all directed and random passes issued");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_readback_checker.md
# ram_readback_checker

Sequential read-back verifier for the 4-word RAM / 16-word ROM pair. On `start`, it reads every RAM word and compares it with the ROM word at `rom_base + index`, then reports pass/fail, the mismatch count and the first failing RAM address. It is the reader side of the ROM→RAM copy path: it consumes what the copy writer left in RAM and drives the RAM only in read mode (`RW=0`).

## Interface
Parameters:
- `DATA_W`, 16: data word width of both memories.
- `RAM_AW`, 2: RAM address width (depth 4).
- `ROM_AW`, 4: ROM address width (depth 16).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a check pass. Sampled in IDLE only.
- `rom_base`  in  ROM_AW  ROM address compared against RAM word 0. Latched at start.
- `ram_addr`  out  RAM_AW  RAM address.
- `ram_rw`  out  1  RAM read/write select. Constant 0 (read).
- `ram_cs`  out  1  RAM chip select.
- `ram_data`  in  DATA_W  RAM read data (combinational from `ram_addr`).
- `rom_addr`  out  ROM_AW  ROM address.
- `rom_data`  in  DATA_W  ROM read data (combinational from `rom_addr`).
- `busy`  out  1  high from the cycle after start is accepted until DONE ends.
- `done`  out  1  one-cycle pulse when results are valid.
- `pass`  out  1  1 when `mismatch_count == 0`. Held until the next accepted start.
- `mismatch_count`  out  3  number of differing words, 0..4.
- `first_fail_addr`  out  RAM_AW  RAM address of the first mismatch. 0 if none.

## Operation
- State machine:
  - IDLE →(start)→ ISSUE → CMP.
  - CMP → ISSUE while `idx != 3`.
  - CMP → DONE when `idx == 3`.
  - DONE → IDLE unconditionally.
- Accepting start in IDLE:
  - latches `rom_base` into `base_q`;
  - clears `idx`, `mismatch_count`, `first_fail_addr` and `pass`;
  - moves to ISSUE.
- Address generation:
  - `ram_addr = idx`.
  - `rom_addr = (base_q + idx) mod 16`: 4-bit add, carry dropped, so the ROM address wraps.
  - Both addresses are registered and stable for the whole ISSUE+CMP pair.
- ISSUE: drives `ram_cs=1` with the addresses. No comparison in this state.
- CMP:
  - `ram_cs` stays 1. On the exiting edge, compares `ram_data` against `rom_data`, all DATA_W bits.
  - On a mismatch, `mismatch_count` increments. If this is the first mismatch of the pass, `first_fail_addr` captures `idx`.
  - `idx` increments when leaving to ISSUE.
- DONE:
  - `ram_cs=0`, `done=1`.
  - `pass = (mismatch_count == 0)` is registered on entry to DONE and held in IDLE.
- `start` in any state other than IDLE is ignored; there is no queuing. `start` held high through DONE is accepted again in the following IDLE cycle.
- `ram_rw` is tied to 0. The block never writes memory.
- Reset values, applied asynchronously on `reset_n` low:
  - all outputs are 0: `ram_addr`, `rom_addr`, `ram_cs`, `busy`, `done`, `pass`, `mismatch_count`, `first_fail_addr`;
  - state is IDLE, `idx=0`.
- Reset mid-operation aborts the pass immediately. No partial result survives.
- Results (`pass`, `mismatch_count`, `first_fail_addr`) are held after DONE until the next accepted start.

## Timing
- Let edge E0 be the edge that samples `start=1` in IDLE.
- Word *i* (i = 0..3):
  - ISSUE occupies the cycle after edge E(2i);
  - CMP occupies the cycle after edge E(2i+1);
  - the comparison takes effect at edge E(2i+2).
- DONE is the cycle after edge E8: `done=1` for exactly one cycle. IDLE resumes after E9.
- Start-to-done latency is 9 clock edges. Back-to-back passes are possible every 10 cycles.
- `busy` is high during the cycles after E0 through E8 (9 cycles) and low in IDLE.
- Memory read paths are combinational and must settle within one cycle. Data is sampled only at the end of CMP, giving a full cycle of address setup.
- Asynchronous reset deassertion is synchronous to `clock`. The first `start` is honoured at the first rising edge with `reset_n=1`.

## Test plan
- RAM pre-loaded with `0x000C`, `0x000D`, `0x000E`, `0x0069` and ROM as initialised, `rom_base=12`, one-cycle start → `done` 9 edges after start, `pass=1`, `mismatch_count=0`, `first_fail_addr=0`.
- Same as above, but RAM[2] changed to `0x00FF` → `pass=0`, `mismatch_count=1`, `first_fail_addr=2`.
- RAM all `0x0000`, `rom_base=1` → `pass=0`, `mismatch_count=4`, `first_fail_addr=0`. `ram_rw` observed 0 throughout.
- `rom_base=14`, RAM = {`0x000E`, `0x0069`, `0x0000`, `0x0001`} → `rom_addr` sequence 14, 15, 0, 1 (wrap), `pass=1`.
- `start` pulsed again during CMP of word 1 → ignored. Exactly one `done`, and `busy` drops after DONE.
- Drop `reset_n` low in the middle of word 2's CMP → immediately `busy=0`, `ram_cs=0`, `mismatch_count=0`, `pass=0`, and no `done`. A new start after release completes normally in 9 edges.
